// File: rtl/bus_resp_pkg.sv
// bus_resp_pkg: address map, MMIO offsets, CTRL/STATUS bits and region decode for bus_resp.
package bus_resp_pkg;
  typedef enum logic [1:0] {RG_RAM, RG_MMIO, RG_VEC, RG_NONE} region_t;
  localparam logic [15:0] RAM_END = 16'h1FFF;
  localparam logic [15:0] MMIO_BASE = 16'h4020;
  localparam logic [15:0] VEC_BASE = 16'hFFFA;
  localparam logic [2:0] OFF_BPL = 3'd0;
  localparam logic [2:0] OFF_BPH = 3'd1;
  localparam logic [2:0] OFF_CTRL = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_CNT_LO = 3'd4;
  localparam logic [2:0] OFF_CNT_HI = 3'd5;
  localparam int CTRL_EN = 0;
  localparam int CTRL_CLR = 1;
  localparam int STATUS_HIT = 0;
  function automatic region_t decode(input logic [15:0] a);
    if (a <= RAM_END) return RG_RAM;
    if (a[15:3] == MMIO_BASE[15:3]) return RG_MMIO;
    if (a >= VEC_BASE) return RG_VEC;
    return RG_NONE;
  endfunction
endpackage

// File: rtl/bus_resp_ram.sv
// bus_resp_ram: 2048x8 synchronous single-port RAM, write-first.
module bus_resp_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [10:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  q
);
  logic [7:0] mem [2048];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    q <= we ? din : mem[addr];
  end
endmodule

// File: rtl/bus_resp.sv
// bus_resp: CPU bus responder with mirrored RAM, vectors, breakpoint MMIO.
// Optional fetch counter at $4024/$4025 when BUS_RESP_FETCH_CNT_EN is defined.
module bus_resp
  import bus_resp_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = 16'h8000,
  parameter logic [15:0] NMI_VEC = 16'h8000,
  parameter logic [15:0] IRQ_VEC = 16'h8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        rw,
  input  logic        sync,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        bp_hit
);
  region_t rg;
  logic [2:0] off;
  logic [7:0] bpl, bph, ram_q, mmio_q, cnt_q, rd_data, p_data;
  logic [15:0] vec;
  logic bp_en, hit, p_rw, p_ram, mmio_wr, bp_set;
  assign rg = decode(a);
  assign off = a[2:0];
  assign mmio_wr = !rw && rg == RG_MMIO;
  assign bp_set = sync && rw && bp_en && a == {bph, bpl};
  assign bp_hit = hit;
  bus_resp_ram u_ram (
    .clk(clk),
    .we(!rst && !rw && rg == RG_RAM),
    .addr(a[10:0]),
    .din(d_in),
    .q(ram_q)
  );
`ifdef BUS_RESP_FETCH_CNT_EN
  logic [15:0] cnt;
  logic [7:0] shadow;
  assign cnt_q = off == OFF_CNT_LO ? cnt[7:0] : off == OFF_CNT_HI ? shadow : 8'hFF;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      shadow <= '0;
    end else begin
      if (mmio_wr && (off == OFF_CNT_LO || off == OFF_CNT_HI)) cnt <= '0;
      else if (sync) cnt <= cnt + 16'd1;
      if (rw && rg == RG_MMIO && off == OFF_CNT_LO) shadow <= cnt[15:8];
    end
  end
`else
  assign cnt_q = 8'hFF;
`endif
  always_comb begin
    vec = a[2:1] == 2'b01 ? NMI_VEC : a[2:1] == 2'b10 ? RESET_VEC : IRQ_VEC;
    mmio_q = off == OFF_BPL ? bpl :
             off == OFF_BPH ? bph :
             off == OFF_CTRL ? {7'b0, bp_en} :
             off == OFF_STATUS ? {7'b0, hit} : cnt_q;
    rd_data = rg == RG_MMIO ? mmio_q : rg == RG_VEC ? (a[0] ? vec[15:8] : vec[7:0]) : 8'hFF;
  end
  // Stage 1 captures the access at the sample edge; stage 2 presents it one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_rw <= 1'b0;
      p_ram <= 1'b0;
      p_data <= 8'hFF;
      d_out <= 8'hFF;
      d_oe <= 1'b0;
      bpl <= '0;
      bph <= '0;
      bp_en <= 1'b0;
      hit <= 1'b0;
    end else begin
      p_rw <= rw;
      p_ram <= rg == RG_RAM;
      p_data <= rd_data;
      d_oe <= p_rw;
      d_out <= p_rw ? (p_ram ? ram_q : p_data) : 8'hFF;
      if (mmio_wr && off == OFF_BPL) bpl <= d_in;
      if (mmio_wr && off == OFF_BPH) bph <= d_in;
      if (mmio_wr && off == OFF_CTRL) bp_en <= d_in[CTRL_EN];
      hit <= bp_set || (hit && !(mmio_wr && off == OFF_CTRL && d_in[CTRL_CLR]));
    end
  end
endmodule

// File: tb/tb_bus_resp.sv
// tb_bus_resp: directed self-checking bench for bus_resp.
module tb_bus_resp;
  logic clk = 1'b0, rst = 1'b1, rw = 1'b1, sync = 1'b0;
  logic [15:0] a = 16'h5000;
  logic [7:0] d_in = 8'h00, d_out;
  logic d_oe, bp_hit;
  int total = 0, bad = 0;

  bus_resp #(.RESET_VEC(16'h8000), .NMI_VEC(16'hC123), .IRQ_VEC(16'hD456)) dut (
    .clk(clk), .rst(rst), .a(a), .rw(rw), .sync(sync), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] aa, input logic r, input logic s, input logic [7:0] d);
    a = aa; rw = r; sync = s; d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] aa, input logic [7:0] d);
    cyc(aa, 1'b0, 1'b0, d);
  endtask

  task automatic rd(input logic [15:0] aa, input logic [7:0] exp, input string tag);
    cyc(aa, 1'b1, 1'b0, 8'h00);
    cyc(16'h5000, 1'b1, 1'b0, 8'h00);
    chk(tag, d_out, exp);
    chk({tag, "_oe"}, {7'b0, d_oe}, 8'h01);
  endtask

  task automatic syncs(input int n);
    for (int i = 0; i < n; i++) cyc(16'h5000, 1'b1, 1'b1, 8'h00);
  endtask

  initial begin
    cyc(16'h5000, 1'b1, 1'b0, 8'h00);
    cyc(16'h5000, 1'b1, 1'b0, 8'h00);
    chk("rst_dout", d_out, 8'hFF);
    chk("rst_doe", {7'b0, d_oe}, 8'h00);
    chk("rst_hit", {7'b0, bp_hit}, 8'h00);
    rst = 1'b0;
    rd(16'hFFFC, 8'h00, "vec_fffc");
    rd(16'hFFFD, 8'h80, "vec_fffd");
    rd(16'hFFFA, 8'h23, "vec_fffa");
    rd(16'hFFFB, 8'hC1, "vec_fffb");
    rd(16'hFFFE, 8'h56, "vec_fffe");
    rd(16'hFFFF, 8'hD4, "vec_ffff");
    wr(16'hFFFC, 8'h12);
    rd(16'hFFFC, 8'h00, "vec_wr_ignored");
    wr(16'h0123, 8'h55);
    cyc(16'h5000, 1'b1, 1'b0, 8'h00);
    chk("wr_dout", d_out, 8'hFF);
    chk("wr_doe", {7'b0, d_oe}, 8'h00);
    rd(16'h0923, 8'h55, "ram_mirror");
    wr(16'h0456, 8'hA5);
    rd(16'h1456, 8'hA5, "ram_wr_then_rd");
    rd(16'h5000, 8'hFF, "unmapped");
    wr(16'h4020, 8'h34);
    wr(16'h4021, 8'h12);
    wr(16'h4022, 8'h01);
    rd(16'h4020, 8'h34, "bpl");
    rd(16'h4021, 8'h12, "bph");
    rd(16'h4022, 8'h01, "ctrl");
    rd(16'h4023, 8'h00, "status0");
    cyc(16'h1234, 1'b1, 1'b1, 8'h00);
    chk("bp_set", {7'b0, bp_hit}, 8'h01);
    rd(16'h4023, 8'h01, "status1");
    wr(16'h4022, 8'h03);
    chk("bp_clr_keep_en", {7'b0, bp_hit}, 8'h00);
    cyc(16'h1234, 1'b1, 1'b1, 8'h00);
    chk("bp_reset_after_clr", {7'b0, bp_hit}, 8'h01);
    wr(16'h4022, 8'h03);
    cyc(16'h1234, 1'b1, 1'b0, 8'h00);
    chk("bp_nosync", {7'b0, bp_hit}, 8'h00);
    wr(16'h4020, 8'h56);
    cyc(16'h1234, 1'b1, 1'b1, 8'h00);
    chk("bp_old_addr", {7'b0, bp_hit}, 8'h00);
    cyc(16'h1256, 1'b1, 1'b1, 8'h00);
    chk("bp_new_addr", {7'b0, bp_hit}, 8'h01);
    wr(16'h4022, 8'h02);
    chk("bp_clr", {7'b0, bp_hit}, 8'h00);
    cyc(16'h1256, 1'b1, 1'b1, 8'h00);
    chk("bp_disabled", {7'b0, bp_hit}, 8'h00);
`ifdef BUS_RESP_FETCH_CNT_EN
    wr(16'h4024, 8'h00);
    syncs(300);
    rd(16'h4024, 8'h2C, "cnt_lo");
    syncs(10);
    rd(16'h4025, 8'h01, "cnt_shadow");
    wr(16'h4025, 8'h00);
    syncs(65535);
    rd(16'h4024, 8'hFF, "cnt_ffff_lo");
    rd(16'h4025, 8'hFF, "cnt_ffff_hi");
    syncs(1);
    rd(16'h4024, 8'h00, "cnt_wrap_lo");
    rd(16'h4025, 8'h00, "cnt_wrap_hi");
`else
    wr(16'h4024, 8'h00);
    syncs(3);
    rd(16'h4024, 8'hFF, "cnt_lo_unmapped");
    rd(16'h4025, 8'hFF, "cnt_hi_unmapped");
`endif
    wr(16'h0200, 8'h77);
    rd(16'h0200, 8'h77, "ram_pre_rst");
    wr(16'h4022, 8'h01);
    cyc(16'h1256, 1'b1, 1'b1, 8'h00);
    chk("bp_pre_rst", {7'b0, bp_hit}, 8'h01);
    cyc(16'h0200, 1'b1, 1'b0, 8'h00);
    rst = 1'b1;
    cyc(16'h0200, 1'b0, 1'b0, 8'h99);
    chk("midrst_dout", d_out, 8'hFF);
    chk("midrst_doe", {7'b0, d_oe}, 8'h00);
    chk("midrst_hit", {7'b0, bp_hit}, 8'h00);
    rst = 1'b0;
    rd(16'h4023, 8'h00, "status_after_rst");
    rd(16'h4020, 8'h00, "bpl_after_rst");
    rd(16'h4022, 8'h00, "ctrl_after_rst");
    rd(16'h0200, 8'h77, "ram_kept");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_resp.md
BUS_RESP -- requirements
Module: bus_resp

Interface
REQ-001 Parameter RESET_VEC, default 16'h8000: value returned for reads at $FFFC/$FFFD (low/high byte).
REQ-002 Parameter NMI_VEC, default 16'h8000: value returned for reads at $FFFA/$FFFB.
REQ-003 Parameter IRQ_VEC, default 16'h8000: value returned for reads at $FFFE/$FFFF.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 a  input  16  CPU address bus.
REQ-008 rw  input  1  1 = CPU read, 0 = CPU write.
REQ-009 sync  input  1  high during opcode-fetch cycle.
REQ-010 d_in  input  8  CPU write data.
REQ-011 d_out  output  8  read data returned to CPU.
REQ-012 d_oe  output  1  high when d_out is valid read data.
REQ-013 bp_hit  output  1  sticky breakpoint-hit flag.

Function
REQ-014 Read latency SHALL be one cycle: a/rw sampled at edge N, d_out/d_oe valid after edge N+1, held until next sampled access.
REQ-015 d_oe SHALL equal the registered rw of the previous cycle; d_out during a write cycle SHALL be 8'hFF.
REQ-016 $0000-$1FFF: 2 KiB RAM, mirrored, index a[10:0]; write commits at the sampling edge when rw=0.
REQ-017 Read of RAM byte written in immediately preceding cycle SHALL return the new value.
REQ-018 $FFFA-$FFFF: vector bytes per REQ-001..003; writes ignored.
REQ-019 MMIO: $4020 BPL (r/w), $4021 BPH (r/w), $4022 CTRL (r/w; bit0 bp_en, bit1 write-1 clear hit, reads 0), $4023 STATUS (read-only; bit0 hit, bits7:1 zero).
REQ-020 Breakpoint: sync=1, rw=1, bp_en=1, a=={BPH,BPL} at edge N SHALL set hit after edge N; bp_hit = hit.
REQ-021 Set and CTRL bit1 clear in same cycle: set SHALL win.
REQ-022 Writing BPL/BPH SHALL take effect for the sync cycle following the write edge, not the write cycle itself.
REQ-023 All other addresses: reads return 8'hFF, writes ignored.

Reset
REQ-024 rst high at an edge SHALL clear: d_out=8'hFF, d_oe=0, BPL=BPH=0, bp_en=0, hit=0, fetch counter=0, shadow=0.
REQ-025 RAM contents SHALL NOT be reset; an access sampled while rst=1 SHALL be dropped (no write commit).
REQ-026 Reset asserted mid-access SHALL override the pending read result on the same edge.

Configuration
REQ-027 Macro BUS_RESP_FETCH_CNT_EN defined: 16-bit counter increments on each edge where sync=1 and rst=0, wraps $FFFF->$0000; $4024 reads low byte and copies high byte into shadow; $4025 reads shadow; writes to either clear counter.
REQ-028 Macro undefined: no counter/shadow logic; $4024/$4025 behave as unmapped (REQ-023).

Structure
REQ-029 Package bus_resp_pkg SHALL hold region address constants, MMIO offsets, CTRL/STATUS bit indices, and the region-decode enum (RAM, MMIO, VEC, NONE).
REQ-030 One sub-module bus_resp_ram: 2048x8 synchronous RAM, one read/write port, write-first.

Verification
REQ-031 Write $55 to $0123, read $0923 -> d_out=$55, d_oe=1 one cycle after read sample.
REQ-032 After reset, read $FFFC then $FFFD -> $00 then $80; write $12 to $FFFC, reread -> still $00.
REQ-033 BPL=$34, BPH=$12, CTRL=$01; sync read at $1234 -> bp_hit=1 next cycle; CTRL=$02 coincident with another sync at $1234 -> bp_hit stays 1; CTRL=$02 alone -> bp_hit=0.
REQ-034 (FETCH_CNT_EN) 300 sync cycles, read $4024 -> $2C, then 10 more syncs, read $4025 -> $01; preload via 65536 syncs -> wraps to $0000.
REQ-035 Read $5000 -> $FF; write during any access then rst=1 mid-access -> d_oe=0, d_out=$FF, STATUS=$00, RAM target unchanged.
